alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu.sv | 54 +++++
 rtl/alu_rr_arb.sv | 57 +++++
 rtl/alu_arbiter.sv | 97 +++++++++
 tb/tb_alu_arbiter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcodes, flag bit positions and arbiter FSM states.
package alu_pkg;
    localparam int DATA_W = 16;
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_R = 3;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SETC  = 3'b001,
        OP_SUB   = 3'b010,
        OP_AND   = 3'b011,
        OP_NOT   = 3'b100,
        OP_PASSA = 3'b101,
        OP_PASSB = 3'b110,
        OP_NOP   = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } arb_state_e;
endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU with condition-code update; bit3 of the CCR is
// reserved and always passes through untouched.
module alu
    import alu_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        flags_in,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags_out
);
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic            upd_zn;

    assign sum  = {1'b0, a} + {1'b0, b};
    // Top bit of the widened subtract is the unsigned borrow (b > a).
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result    = '0;
        flags_out = flags_in;
        upd_zn    = 1'b0;
        case (op)
            OP_ADD: begin
                result            = sum[DATA_W-1:0];
                flags_out[FLAG_C] = sum[DATA_W];
                upd_zn            = 1'b1;
            end
            OP_SETC: flags_out[FLAG_C] = 1'b1;
            OP_SUB: begin
                result            = diff[DATA_W-1:0];
                flags_out[FLAG_C] = diff[DATA_W];
                upd_zn            = 1'b1;
            end
            OP_AND: begin
                result = a & b;
                upd_zn = 1'b1;
            end
            OP_NOT: begin
                result = ~a;
                upd_zn = 1'b1;
            end
            OP_PASSA: result = a;
            OP_PASSB: result = b;
            OP_NOP:   result = '0;
        endcase
        if (upd_zn) begin
            flags_out[FLAG_Z] = (result == '0);
            flags_out[FLAG_N] = result[DATA_W-1];
        end
    end
endmodule

// File: rtl/alu_rr_arb.sv
// Two-requester round-robin grant. Optional lock (ALU_ARB_LOCK_EN) keeps the
// grant with the owner while it keeps requesting.
module alu_rr_arb (
    input  logic       clk,
    input  logic       reset_b,
    input  logic [1:0] req_valid,
    input  logic [1:0] req_lock,
    input  logic       can_accept,
    output logic       gnt_id,
    output logic       accept,
    output logic [1:0] req_ready
);
    logic last_q, last_d;

`ifdef ALU_ARB_LOCK_EN
    logic lock_q, lock_d;
    logic lock_id_q, lock_id_d;
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
`endif

    always_comb begin
        gnt_id = (req_valid == 2'b11) ? ~last_q : req_valid[1];
`ifdef ALU_ARB_LOCK_EN
        // An owner that stops requesting releases exclusivity so the other side cannot starve.
        if (lock_q && req_valid[lock_id_q]) gnt_id = lock_id_q;
`endif
        accept    = (|req_valid) && can_accept;
        req_ready = accept ? (2'b01 << gnt_id) : 2'b00;
        last_d    = accept ? gnt_id : last_q;
`ifdef ALU_ARB_LOCK_EN
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (accept) begin
            lock_d    = req_lock[gnt_id];
            lock_id_d = gnt_id;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            last_q <= 1'b1;
`ifdef ALU_ARB_LOCK_EN
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
`endif
        end else begin
            last_q <= last_d;
`ifdef ALU_ARB_LOCK_EN
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
`endif
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between decode/execute (id 0) and the aux sequencer (id 1),
// with a registered response and CCR. Grant lock enabled by ALU_ARB_LOCK_EN.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_b,
    input  logic [1:0]        req_valid,
    input  logic [2:0]        req_op0,
    input  logic [2:0]        req_op1,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [1:0]        req_lock,
    output logic [1:0]        req_ready,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    input  logic              rsp_ready,
    output logic [3:0]        flags,
    input  logic              flags_ld,
    input  logic [3:0]        flags_ld_val
);
    arb_state_e        state_q, state_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]        flags_q, flags_d;

    logic              can_accept, accept, gnt_id;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_a, alu_b, alu_res;
    logic [3:0]        alu_flags;

    // A held response blocks new accepts unless it is being consumed this cycle.
    assign can_accept = (state_q == ST_IDLE) || rsp_ready;

    alu_rr_arb u_arb (
        .clk        (clk),
        .reset_b    (reset_b),
        .req_valid  (req_valid),
        .req_lock   (req_lock),
        .can_accept (can_accept),
        .gnt_id     (gnt_id),
        .accept     (accept),
        .req_ready  (req_ready)
    );

    assign alu_op = gnt_id ? req_op1 : req_op0;
    assign alu_a  = gnt_id ? req_a1  : req_a0;
    assign alu_b  = gnt_id ? req_b1  : req_b0;

    alu u_alu (
        .op        (alu_op),
        .a         (alu_a),
        .b         (alu_b),
        .flags_in  (flags_q),
        .result    (alu_res),
        .flags_out (alu_flags)
    );

    always_comb begin
        state_d      = state_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        flags_d      = flags_q;
        if (accept) begin
            state_d      = ST_RESP;
            rsp_id_d     = gnt_id;
            rsp_result_d = alu_res;
            flags_d      = alu_flags;
        end else if (state_q == ST_RESP && rsp_ready) begin
            state_d = ST_IDLE;
        end
        // Interrupt restore overrides whatever the ALU computed this cycle.
        if (flags_ld) flags_d = flags_ld_val;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q      <= ST_IDLE;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            flags_q      <= 4'b0000;
        end else begin
            state_q      <= state_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            flags_q      <= flags_d;
        end
    end

    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign flags      = flags_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus queues expected responses, a
// negedge monitor pops and compares each consumed response.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic [1:0]  req_valid = '0, req_lock = '0;
    logic [2:0]  req_op0 = '0, req_op1 = '0;
    logic [15:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [1:0]  req_ready;
    logic        rsp_valid, rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_ready = 1'b1;
    logic [3:0]  flags;
    logic        flags_ld = 1'b0;
    logic [3:0]  flags_ld_val = '0;

    typedef struct packed {
        logic        id;
        logic [15:0] res;
        logic [3:0]  fl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_pass = 0;

    alu_arbiter dut (
        .clk(clk), .reset_b(reset_b), .req_valid(req_valid),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_lock(req_lock), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_ready(rsp_ready), .flags(flags),
        .flags_ld(flags_ld), .flags_ld_val(flags_ld_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (reset_b && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_without_expect", {31'b0, rsp_valid}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp", {11'b0, rsp_id, rsp_result, flags}, {11'b0, mon_e.id, mon_e.res, mon_e.fl});
            end
        end
    end

    // Waits (bounded) for a grant, checks it went to the expected requester,
    // queues the expected response and steps past the accepting edge.
    task automatic accept_cycle(input logic id, input logic [15:0] res, input logic [3:0] fl, input bit push);
        int w = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("req_ready", {30'b0, req_ready}, {30'b0, (id ? 2'b10 : 2'b01)});
        if (push) sb.push_back(exp_t'{id, res, fl});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

    initial begin
        #12;
        check("rst_rsp_valid",  {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_id",     {31'b0, rsp_id}, 32'd0);
        check("rst_rsp_result", {16'b0, rsp_result}, 32'd0);
        check("rst_flags",      {28'b0, flags}, 32'd0);
        check("rst_req_ready",  {30'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        reset_b = 1'b1;

        // 0x7FFF + 1 -> 0x8000, N set only
        req_op0 = OP_ADD; req_a0 = 16'h7FFF; req_b0 = 16'h0001; req_valid = 2'b01;
        accept_cycle(1'b0, 16'h8000, 4'b0010, 1'b1);
        req_valid = 2'b00;

        req_op1 = OP_ADD; req_a1 = 16'h0001; req_b1 = 16'h0001; req_valid = 2'b10;
        accept_cycle(1'b1, 16'h0002, 4'b0000, 1'b1);
        req_valid = 2'b00;

        // Both requesting, last served was 1 -> alternate 0,1,0,1
        req_op0 = OP_AND; req_a0 = 16'hF0F0; req_b0 = 16'hFF00;
        req_op1 = OP_SUB; req_a1 = 16'h0005; req_b1 = 16'h0005;
        req_valid = 2'b11;
        repeat (2) begin
            accept_cycle(1'b0, 16'hF000, 4'b0010, 1'b1);
            accept_cycle(1'b1, 16'h0000, 4'b0001, 1'b1);
        end
        req_valid = 2'b00;
        idle(2);

        // 3 - 5 with consumer stalled: borrow and negative, outputs frozen
        rsp_ready = 1'b0;
        req_op0 = OP_SUB; req_a0 = 16'h0003; req_b0 = 16'h0005; req_valid = 2'b01;
        accept_cycle(1'b0, 16'hFFFE, 4'b0110, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("stall_valid",  {31'b0, rsp_valid}, 32'd1);
            check("stall_result", {16'b0, rsp_result}, 32'h0000FFFE);
            check("stall_id",     {31'b0, rsp_id}, 32'd0);
            check("stall_flags",  {28'b0, flags}, 32'b0110);
            check("stall_ready",  {30'b0, req_ready}, 32'd0);
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        idle(1);

        // CCR load wins over the ALU flags; result still 0xFFFF+1 = 0
        flags_ld = 1'b1; flags_ld_val = 4'b1000;
        req_op0 = OP_ADD; req_a0 = 16'hFFFF; req_b0 = 16'h0001; req_valid = 2'b01;
        accept_cycle(1'b0, 16'h0000, 4'b1000, 1'b1);
        flags_ld = 1'b0; req_valid = 2'b00;

        req_op1 = OP_SETC; req_valid = 2'b10;
        accept_cycle(1'b1, 16'h0000, 4'b1100, 1'b1);
        req_op0 = OP_PASSA; req_a0 = 16'h1234; req_valid = 2'b01;
        accept_cycle(1'b0, 16'h1234, 4'b1100, 1'b1);

        // Requester 1 asks for a lock while requester 0 keeps requesting
        req_op0 = OP_PASSB; req_b0 = 16'h00AA;
        req_op1 = OP_PASSA; req_a1 = 16'h0BBB;
        req_lock = 2'b10; req_valid = 2'b11;
`ifdef ALU_ARB_LOCK_EN
        repeat (3) accept_cycle(1'b1, 16'h0BBB, 4'b1100, 1'b1);
`else
        accept_cycle(1'b1, 16'h0BBB, 4'b1100, 1'b1);
        accept_cycle(1'b0, 16'h00AA, 4'b1100, 1'b1);
        accept_cycle(1'b1, 16'h0BBB, 4'b1100, 1'b1);
`endif
        req_lock = 2'b00; req_valid = 2'b01;
        accept_cycle(1'b0, 16'h00AA, 4'b1100, 1'b1);
        req_valid = 2'b00;
        idle(2);

        // Reset while holding a response: dropped, never replayed
        rsp_ready = 1'b0;
        req_op0 = OP_SUB; req_a0 = 16'h0003; req_b0 = 16'h0005; req_valid = 2'b01;
        accept_cycle(1'b0, 16'hFFFE, 4'b1110, 1'b0);
        req_valid = 2'b00;
        #2 reset_b = 1'b0;
        #1;
        check("async_rst_valid",  {31'b0, rsp_valid}, 32'd0);
        check("async_rst_flags",  {28'b0, flags}, 32'd0);
        check("async_rst_result", {16'b0, rsp_result}, 32'd0);
        @(posedge clk); #1;
        reset_b = 1'b1; rsp_ready = 1'b1;

        req_op0 = OP_ADD; req_a0 = 16'h0001; req_b0 = 16'h0001;
        req_op1 = OP_ADD; req_a1 = 16'h0002; req_b1 = 16'h0002;
        req_valid = 2'b11;
        accept_cycle(1'b0, 16'h0002, 4'b0000, 1'b1);
        req_valid = 2'b00;
        idle(3);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
